// File: rtl/rcv_bit_timer_if.sv
// rcv_bit_timer_if: control, config and status signals between the receiver front end and the bit timer
interface rcv_bit_timer_if #(
    parameter int CNT_WIDTH = 14,
    parameter int BITS_WIDTH = 4
);
    logic enable_timer;
    logic [CNT_WIDTH-1:0] bit_period;
    logic [BITS_WIDTH-1:0] bits_per_packet;
    logic shift_strobe;
    logic packet_done;
    logic busy;
    logic [BITS_WIDTH-1:0] bit_index;
    modport master (
        output enable_timer, bit_period, bits_per_packet,
        input shift_strobe, packet_done, busy, bit_index
    );
    modport slave (
        input enable_timer, bit_period, bits_per_packet,
        output shift_strobe, packet_done, busy, bit_index
    );
endinterface

// File: rtl/rcv_bit_timer.sv
// rcv_bit_timer: programmable bit-sample strobe and end-of-packet timer with abort and re-arm interlock
// Define RCV_TIMER_MIDBIT_EN to stretch the first interval to 1.5 periods (mid-bit first sample)
module rcv_bit_timer #(
    parameter int CNT_WIDTH = 14,
    parameter int BITS_WIDTH = 4
) (
    input logic clk,
    input logic n_rst,
    rcv_bit_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t state, state_n;
    logic [CNT_WIDTH:0] cnt, cnt_n, ivl, ivl_n;
    logic [CNT_WIDTH-1:0] pl, pl_n;
    logic [BITS_WIDTH-1:0] nl, nl_n, idx, idx_n;
    logic done_n;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            cnt <= '0;
            ivl <= '0;
            pl <= '0;
            nl <= '0;
            idx <= '0;
            bus.shift_strobe <= 1'b0;
            bus.packet_done <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            cnt <= cnt_n;
            ivl <= ivl_n;
            pl <= pl_n;
            nl <= nl_n;
            idx <= idx_n;
            bus.shift_strobe <= state_n == RUN && cnt_n == ivl_n;
            bus.packet_done <= done_n;
            bus.busy <= state_n == RUN;
        end
    assign bus.bit_index = idx;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        ivl_n = ivl;
        pl_n = pl;
        nl_n = nl;
        idx_n = idx;
        done_n = 1'b0;
        case (state)
            IDLE:
                if (bus.enable_timer) begin
                    pl_n = bus.bit_period < CNT_WIDTH'(2) ? CNT_WIDTH'(2) : bus.bit_period;
                    nl_n = bus.bits_per_packet == '0 ? BITS_WIDTH'(1) : bus.bits_per_packet;
`ifdef RCV_TIMER_MIDBIT_EN
                    ivl_n = {1'b0, pl_n} + {2'b0, pl_n[CNT_WIDTH-1:1]};
`else
                    ivl_n = {1'b0, pl_n};
`endif
                    cnt_n = (CNT_WIDTH+1)'(1);
                    idx_n = '0;
                    state_n = RUN;
                end
            RUN:
                if (!bus.enable_timer) begin
                    state_n = IDLE;
                    cnt_n = '0;
                    idx_n = '0;
                end else if (cnt == ivl) begin
                    idx_n = idx + BITS_WIDTH'(1);
                    cnt_n = (CNT_WIDTH+1)'(1);
                    ivl_n = {1'b0, pl};
                    if (idx_n == nl) begin
                        state_n = HOLD;
                        cnt_n = '0;
                        done_n = 1'b1;
                    end
                end else cnt_n = cnt + (CNT_WIDTH+1)'(1);
            HOLD:
                if (!bus.enable_timer) begin
                    state_n = IDLE;
                    idx_n = '0;
                end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rcv_bit_timer.sv
// tb_rcv_bit_timer: directed checks of strobe timing, packet_done, abort, clamp, config latch, reset and re-arm
module tb_rcv_bit_timer;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int checks = 0;
    int errors = 0;
    rcv_bit_timer_if #(.CNT_WIDTH(14), .BITS_WIDTH(4)) bus ();
    rcv_bit_timer #(.CNT_WIDTH(14), .BITS_WIDTH(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input int c, input int es, input int ed, input int eb, input int ei);
        chk("shift_strobe", c, 32'(bus.shift_strobe), es);
        chk("packet_done", c, 32'(bus.packet_done), ed);
        chk("busy", c, 32'(bus.busy), eb);
        chk("bit_index", c, 32'(bus.bit_index), ei);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int p, input int n);
        bus.enable_timer = 1'b0;
        tick();
        tick();
        bus.bit_period = 14'(p);
        bus.bits_per_packet = 4'(n);
        bus.enable_timer = 1'b1;
    endtask

    // p and n are the effective (already clamped) period and bit count
    task automatic run_pkt(input int p, input int n, input int cycles, input int drop_at, input int chg_at);
        int f, last, idx;
        bit aborted;
`ifdef RCV_TIMER_MIDBIT_EN
        f = p + p / 2;
`else
        f = p;
`endif
        last = f + (n - 1) * p;
        idx = 0;
        aborted = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            int es;
            es = (c >= f && c <= last && (c - f) % p == 0) ? 1 : 0;
            if (aborted) chk_all(c, 0, 0, 0, 0);
            else chk_all(c, es, (c == last + 1) ? 1 : 0, (c >= 1 && c <= last) ? 1 : 0, idx);
            if (!aborted && es == 1) idx++;
            if (c == drop_at) begin
                bus.enable_timer = 1'b0;
                aborted = 1'b1;
            end
            if (c == chg_at) bus.bit_period = 14'd20;
            tick();
        end
    endtask

    initial begin
        bus.enable_timer = 1'b0;
        bus.bit_period = 14'd10;
        bus.bits_per_packet = 4'd9;
        #3;
        chk_all(-1, 0, 0, 0, 0);
        tick();
        tick();
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        chk_all(-1, 0, 0, 0, 0);
        start(10, 9);
        run_pkt(10, 9, 142, -1, -1);
        bus.enable_timer = 1'b0;
        tick();
        bus.enable_timer = 1'b1;
        run_pkt(10, 9, 100, -1, -1);
        start(10, 9);
        run_pkt(10, 9, 60, 44, -1);
        bus.enable_timer = 1'b1;
        run_pkt(10, 9, 22, -1, -1);
        start(1, 0);
        run_pkt(2, 1, 8, -1, -1);
        start(10, 3);
        run_pkt(10, 3, 40, -1, 15);
        start(2, 3);
        run_pkt(2, 3, 12, -1, -1);
        start(7, 2);
        run_pkt(7, 2, 30, -1, -1);
        start(10, 9);
        run_pkt(10, 9, 37, -1, -1);
        #3;
        n_rst = 1'b0;
        #1;
        chk_all(37, 0, 0, 0, 0);
        #2;
        n_rst = 1'b1;
        run_pkt(10, 9, 100, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
